fsm_key_scheduler: RTL and testbench

//  Sequences a time-varying key into a locked FSM benchmark (5-in/25-out class, state updated on negedge clk).

---
 rtl/fsm_key_scheduler.sv | 153 +++++++++++++++
 tb/tb_fsm_key_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fsm_key_scheduler.sv
// Key sequencer for a locked FSM: a programmable table of DEPTH key words, played out
// one per clock (one-shot or looped) with hold/stop control and registered outputs.
`timescale 1ns/1ps
module fsm_key_scheduler #(
  parameter int KEY_W = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PTR_W-1:0] cfg_addr,
  input  logic [KEY_W-1:0] cfg_data,
  input  logic [PTR_W-1:0] len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [PTR_W-1:0] step_idx,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [PTR_W-1:0] idx_r, idx_nxt_s;
  logic [PTR_W-1:0] len_r, len_nxt_s;
  logic             loop_r, loop_nxt_s;
  logic [KEY_W-1:0] table_r [DEPTH];
  logic             wr_en_s;

  logic [KEY_W-1:0] key_nxt_s;
  logic             valid_nxt_s, busy_nxt_s, done_nxt_s, cfg_err_nxt_s;
  logic [PTR_W-1:0] step_nxt_s;

  assign wr_en_s = cfg_we && (state_r == ST_IDLE);

  // State, index and latched sequence parameters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {PTR_W{1'b0}};
      len_r   <= {PTR_W{1'b0}};
      loop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      len_r   <= len_nxt_s;
      loop_r  <= loop_nxt_s;
    end
  end

  // Key table: cleared on reset, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_r[i] <= {KEY_W{1'b0}};
    end else if (wr_en_s) begin
      table_r[cfg_addr] <= cfg_data;
    end
  end

  // Next-state and index sequencing; stop outranks hold, wrap and finish
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    len_nxt_s   = len_r;
    loop_nxt_s  = loop_r;
    case (state_r)
      ST_IDLE: begin
        idx_nxt_s = {PTR_W{1'b0}};
        if (start && !stop) begin
          state_nxt_s = ST_RUN;
          len_nxt_s   = len;
          loop_nxt_s  = loop;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = {PTR_W{1'b0}};
        end else if (hold) begin
          idx_nxt_s = idx_r;
        end else if (idx_r != len_r) begin
          idx_nxt_s = idx_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else if (loop_r) begin
          idx_nxt_s = {PTR_W{1'b0}};
        end else begin
          state_nxt_s = ST_DONE;
          idx_nxt_s   = {PTR_W{1'b0}};
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = {PTR_W{1'b0}};
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = {PTR_W{1'b0}};
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state so they align with it
  always_comb begin
    key_nxt_s     = {KEY_W{1'b0}};
    valid_nxt_s   = 1'b0;
    busy_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;
    step_nxt_s    = {PTR_W{1'b0}};
    cfg_err_nxt_s = cfg_we && (state_r != ST_IDLE);
    if (state_nxt_s == ST_RUN) begin
      // a same-edge idle write to the first entry must be visible on entry to RUN
      key_nxt_s   = (wr_en_s && (cfg_addr == idx_nxt_s)) ? cfg_data : table_r[idx_nxt_s];
      valid_nxt_s = 1'b1;
      busy_nxt_s  = 1'b1;
      step_nxt_s  = idx_nxt_s;
    end else if (state_nxt_s == ST_DONE) begin
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out   <= {KEY_W{1'b0}};
      key_valid <= 1'b0;
      step_idx  <= {PTR_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      key_out   <= key_nxt_s;
      key_valid <= valid_nxt_s;
      step_idx  <= step_nxt_s;
      busy      <= busy_nxt_s;
      done      <= done_nxt_s;
      cfg_err   <= cfg_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_fsm_key_scheduler.sv
// Directed self-checking bench for fsm_key_scheduler: table load, one-shot, loop, hold,
// rejected writes, start/stop conflict, len=0 and mid-run reset.
`timescale 1ns/1ps
module tb_fsm_key_scheduler;

  logic       clk = 1'b0;
  logic       rst, cfg_we, loop, start, stop, hold;
  logic [2:0] cfg_addr, len, step_idx;
  logic [7:0] cfg_data, key_out;
  logic       key_valid, busy, done, cfg_err;

  int tests_run    = 0;
  int tests_failed = 0;

  fsm_key_scheduler #(.KEY_W(8), .DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .len(len), .loop(loop), .start(start), .stop(stop), .hold(hold),
    .key_out(key_out), .key_valid(key_valid), .step_idx(step_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // observed outputs packed as {key, valid, busy, done, step, cfg_err}
  task automatic expect_out(input string tag, input logic [7:0] k, input logic v,
                            input logic b, input logic d, input logic [2:0] s, input logic e);
    check_eq(tag, {17'd0, key_out, key_valid, busy, done, step_idx, cfg_err},
                  {17'd0, k, v, b, d, s, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [2:0] l, input logic lp);
    len = l; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] keys [4];

  initial begin
    keys[0] = 8'h11; keys[1] = 8'h22; keys[2] = 8'h33; keys[3] = 8'h44;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h00;
    len = 3'd0; loop = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    tick(); tick();
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("idle_after_reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 4; i++) wr(3'(i), keys[i]);
    expect_out("idle_after_writes", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // 1: one-shot
    go(3'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      expect_out("oneshot_key", keys[k], 1'b1, 1'b1, 1'b0, 3'(k), 1'b0);
    end
    tick();
    expect_out("oneshot_done", 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    expect_out("oneshot_idle", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // 2: looped, stop at second 22
    go(3'd3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k != 0) tick();
      expect_out("loop_key", keys[k % 4], 1'b1, 1'b1, 1'b0, 3'(k % 4), 1'b0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_out("loop_stop", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    expect_out("loop_stop_nodone", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // 3: hold on 22 for 3 cycles
    go(3'd3, 1'b0);
    tick();
    expect_out("hold_pre", 8'h22, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("hold_22", 8'h22, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    end
    hold = 1'b0;
    tick();
    expect_out("hold_33", 8'h33, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
    tick();
    expect_out("hold_44", 8'h44, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    expect_out("hold_done", 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();

    // 4: write during RUN is dropped
    go(3'd3, 1'b0);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'hAA;
    tick();
    cfg_we = 1'b0;
    expect_out("run_write_err", 8'h22, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1);
    tick();
    expect_out("run_write_err_clear", 8'h33, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
    tick(); tick();
    expect_out("run_write_done", 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    go(3'd3, 1'b0);
    tick();
    expect_out("rerun_table1", 8'h22, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // 5: start+stop in IDLE, then len=0 one-shot and looped
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    expect_out("start_stop_idle", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    go(3'd0, 1'b0);
    expect_out("len0_key", 8'h11, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    expect_out("len0_done", 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    expect_out("len0_idle", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    go(3'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("len0_loop", 8'h11, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // 6: reset at third key of a looped run, then rerun on a cleared table
    go(3'd3, 1'b1);
    tick(); tick();
    expect_out("pre_rst_33", 8'h33, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    go(3'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      expect_out("cleared_key", 8'h00, 1'b1, 1'b1, 1'b0, 3'(k), 1'b0);
    end
    tick();
    expect_out("cleared_done", 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
